uart_alu_controller: RTL and testbench

//  Sequencer between the UART receiver, the ALU and the UART transmitter.
//  - Collects three received bytes in order: operand A, operand B, opcode.
//  - Drives the ALU with them and registers the result.
//  - Hands the result to the transmitter and waits for the transmitter to finish.
//  - Guards the frame sequence with an inter-byte timeout counted in baud ticks.

---
 rtl/uart_alu_controller.sv | 165 ++++++++++++++++
 tb/tb_uart_alu_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_controller.sv
// Sequencer between the UART receiver, the ALU and the UART transmitter.
// Collects operand A, operand B and an opcode byte, executes the operation
// on the external ALU, sends the registered result and waits for the
// transmitter to finish. An inter-byte timeout aborts incomplete frames.
module uart_alu_controller #(
    parameter int NB_DATA       = 8,
    parameter int NB_OP         = 6,
    parameter int TIMEOUT_TICKS = 1600
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_op_error,
    output logic               o_timeout,
    output logic               o_overrun
);

    localparam int                NB_CNT  = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [NB_CNT-1:0] CNT_MAX = NB_CNT'(TIMEOUT_TICKS);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_t;

    state_t            state_r;
    logic [NB_CNT-1:0] cnt_r;

    // Opcodes the ALU implements; anything else is rejected before execution.
    function automatic logic op_is_valid(input logic [NB_OP-1:0] op);
        logic valid;
        case (op)
            NB_OP'(6'b100000): valid = 1'b1;  // ADD
            NB_OP'(6'b100010): valid = 1'b1;  // SUB
            NB_OP'(6'b100100): valid = 1'b1;  // AND
            NB_OP'(6'b100101): valid = 1'b1;  // OR
            NB_OP'(6'b100110): valid = 1'b1;  // XOR
            NB_OP'(6'b000011): valid = 1'b1;  // SRA
            NB_OP'(6'b000010): valid = 1'b1;  // SRL
            NB_OP'(6'b100111): valid = 1'b1;  // NOR
            default:           valid = 1'b0;
        endcase
        return valid;
    endfunction

    // Frame sequencer: state, operand capture, timeout counter and all registered outputs.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_op_error <= 1'b0;
            o_timeout  <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            // Status outputs are single-cycle pulses unless re-asserted below.
            o_tx_start <= 1'b0;
            o_op_error <= 1'b0;
            o_timeout  <= 1'b0;
            o_overrun  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= '0;
                    if (i_rx_done) begin
                        o_alu_a <= i_rx_data;
                        state_r <= ST_WAIT_B;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT_B: begin
                    // A received byte always wins over an expiring timeout.
                    if (i_rx_done) begin
                        o_alu_b <= i_rx_data;
                        cnt_r   <= '0;
                        state_r <= ST_WAIT_OP;
                    end else if (cnt_r == CNT_MAX) begin
                        o_timeout <= 1'b1;
                        cnt_r     <= '0;
                        state_r   <= ST_IDLE;
                    end else if (i_tick) begin
                        cnt_r <= cnt_r + NB_CNT'(1);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_WAIT_OP: begin
                    if (i_rx_done) begin
                        o_alu_op <= i_rx_data[NB_OP-1:0];
                        cnt_r    <= '0;
                        if (op_is_valid(i_rx_data[NB_OP-1:0])) begin
                            o_busy  <= 1'b1;
                            state_r <= ST_EXEC;
                        end else begin
                            o_op_error <= 1'b1;
                            state_r    <= ST_IDLE;
                        end
                    end else if (cnt_r == CNT_MAX) begin
                        o_timeout <= 1'b1;
                        cnt_r     <= '0;
                        state_r   <= ST_IDLE;
                    end else if (i_tick) begin
                        cnt_r <= cnt_r + NB_CNT'(1);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_EXEC: begin
                    // Operands have been stable for a full cycle; sample the ALU.
                    cnt_r      <= '0;
                    o_tx_data  <= i_alu_result;
                    o_tx_start <= 1'b1;
                    o_overrun  <= i_rx_done;
                    state_r    <= ST_SEND;
                end
                ST_SEND: begin
                    cnt_r     <= '0;
                    o_overrun <= i_rx_done;
                    state_r   <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    cnt_r <= '0;
                    if (i_tx_done) begin
                        o_busy <= 1'b0;
                        // A byte arriving with tx completion starts the next frame.
                        if (i_rx_done) begin
                            o_alu_a <= i_rx_data;
                            state_r <= ST_WAIT_B;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        o_overrun <= i_rx_done;
                        state_r   <= ST_WAIT_TX;
                    end
                end
                default: begin
                    cnt_r   <= '0;
                    o_busy  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_controller.sv
// Directed self-checking bench for uart_alu_controller. The bench acts as the
// ALU and keeps a scoreboard of expected transmit bytes.
module tb_uart_alu_controller;

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_tick = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_done = 1'b0;
    logic [7:0] i_alu_result;
    logic       i_tx_done = 1'b0;
    logic [7:0] o_alu_a;
    logic [7:0] o_alu_b;
    logic [5:0] o_alu_op;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_busy;
    logic       o_op_error;
    logic       o_timeout;
    logic       o_overrun;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];

    uart_alu_controller #(
        .NB_DATA      (8),
        .NB_OP        (6),
        .TIMEOUT_TICKS(1600)
    ) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_tick      (i_tick),
        .i_rx_data   (i_rx_data),
        .i_rx_done   (i_rx_done),
        .i_alu_result(i_alu_result),
        .i_tx_done   (i_tx_done),
        .o_alu_a     (o_alu_a),
        .o_alu_b     (o_alu_b),
        .o_alu_op    (o_alu_op),
        .o_tx_data   (o_tx_data),
        .o_tx_start  (o_tx_start),
        .o_busy      (o_busy),
        .o_op_error  (o_op_error),
        .o_timeout   (o_timeout),
        .o_overrun   (o_overrun)
    );

    always #5 i_clock = ~i_clock;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
        logic [7:0] r;
        case (op)
            6'h20:   r = a + b;
            6'h22:   r = a - b;
            6'h24:   r = a & b;
            6'h25:   r = a | b;
            6'h26:   r = a ^ b;
            6'h03:   r = 8'($signed(a) >>> b);
            6'h02:   r = a >> b;
            6'h27:   r = ~(a | b);
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Combinational ALU model driven by the controller's operand registers.
    always_comb i_alu_result = alu_f(o_alu_a, o_alu_b, o_alu_op);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        step();
        i_rx_data = b;
        i_rx_done = 1'b1;
        step();
        i_rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        step();
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
        check("busy_after_tx_done", o_busy, 32'd0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            i_tick = 1'b1;
        end
        step();
        i_tick = 1'b0;
    endtask

    // Sends the opcode byte and checks start latency and the transmitted byte.
    task automatic exec_op(input logic [7:0] op, input logic [7:0] exp);
        logic [7:0] want;
        exp_q.push_back(exp);
        send_byte(op);
        check("tx_start_n1", o_tx_start, 32'd0);
        check("busy_exec", o_busy, 32'd1);
        step();
        check("tx_start_n2", o_tx_start, 32'd1);
        check("queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        check("tx_data", o_tx_data, want);
        step();
        check("tx_start_fall", o_tx_start, 32'd0);
        check("busy_wait_tx", o_busy, 32'd1);
        check("tx_data_hold", o_tx_data, want);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                          input logic [7:0] exp);
        send_byte(a);
        send_byte(b);
        exec_op(op, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"}, o_alu_a, 32'd0);
        check({tag, "_b"}, o_alu_b, 32'd0);
        check({tag, "_op"}, o_alu_op, 32'd0);
        check({tag, "_tx_data"}, o_tx_data, 32'd0);
        check({tag, "_flags"}, {o_tx_start, o_busy, o_op_error, o_timeout, o_overrun}, 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        check_all_zero("reset");
        i_reset = 1'b1;

        // ADD, SUB, NOR
        run_op(8'h05, 8'h03, 8'h20, 8'h08);
        repeat (3) begin
            step();
            check("busy_hold", o_busy, 32'd1);
        end
        pulse_tx_done();
        run_op(8'h03, 8'h05, 8'h22, 8'hFE);
        pulse_tx_done();
        run_op(8'hF0, 8'h0F, 8'h27, 8'h00);
        pulse_tx_done();

        // tx_done outside WAIT_TX is ignored; unsupported opcode
        pulse_tx_done();
        send_byte(8'h81);
        send_byte(8'h01);
        send_byte(8'h3F);
        check("op_error_pulse", o_op_error, 32'd1);
        check("op_error_busy", o_busy, 32'd0);
        check("op_error_op_latched", o_alu_op, 32'h3F);
        step();
        check("op_error_fall", o_op_error, 32'd0);
        check("op_error_no_start", o_tx_start, 32'd0);
        step();
        check("op_error_no_start2", o_tx_start, 32'd0);

        // Overrun in WAIT_TX, then a byte coincident with tx_done becomes A
        run_op(8'h40, 8'h01, 8'h20, 8'h41);
        send_byte(8'h55);
        check("overrun_pulse", o_overrun, 32'd1);
        check("overrun_a_kept", o_alu_a, 32'h40);
        step();
        check("overrun_fall", o_overrun, 32'd0);
        check("overrun_busy", o_busy, 32'd1);
        step();
        i_rx_data = 8'h22;
        i_rx_done = 1'b1;
        i_tx_done = 1'b1;
        step();
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        check("coincident_no_overrun", o_overrun, 32'd0);
        check("coincident_a", o_alu_a, 32'h22);
        check("coincident_busy", o_busy, 32'd0);
        send_byte(8'h02);
        exec_op(8'h20, 8'h24);
        pulse_tx_done();

        // Timeout in WAIT_B; operand A untouched, next byte is operand A
        send_byte(8'h10);
        ticks(1600);
        check("timeout_not_yet", o_timeout, 32'd0);
        step();
        check("timeout_pulse", o_timeout, 32'd1);
        check("timeout_a_kept", o_alu_a, 32'h10);
        step();
        check("timeout_fall", o_timeout, 32'd0);
        send_byte(8'h22);
        check("after_timeout_a", o_alu_a, 32'h22);

        // Byte arriving exactly when the timeout expires wins
        ticks(1600);
        i_rx_data = 8'h11;
        i_rx_done = 1'b1;
        step();
        i_rx_done = 1'b0;
        check("expiry_byte_no_timeout", o_timeout, 32'd0);
        check("expiry_byte_b", o_alu_b, 32'h11);
        step();
        check("expiry_byte_no_timeout2", o_timeout, 32'd0);
        exec_op(8'h25, 8'h33);
        pulse_tx_done();

        // Reset during WAIT_TX, then a full sequence
        run_op(8'h07, 8'h09, 8'h20, 8'h10);
        i_reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        step();
        step();
        i_reset = 1'b1;
        repeat (3) begin
            step();
            check("post_reset_no_start", o_tx_start, 32'd0);
            check("post_reset_busy", o_busy, 32'd0);
        end
        run_op(8'h05, 8'h03, 8'h20, 8'h08);
        pulse_tx_done();
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
